// File: rtl/ram_banked_clr.sv
// ram_banked_clr: single-port synchronous RAM split into 2^BANK_W banks.
// Supports bit-masked writes and a registered read with a one-cycle valid
// pulse. An optional engine zeroes every word after reset. Requests that
// arrive while the RAM is not ready are discarded and set a sticky drop flag.
module ram_banked_clr #(
  parameter int DATA_W         = 8,
  parameter int ADDR_W         = 3,
  parameter int BANK_W         = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              CLK_,
  input  logic              RST_N_,
  input  logic              REQ_,
  input  logic              R_W_,
  input  logic [ADDR_W-1:0] ADDR_,
  input  logic [DATA_W-1:0] DATA_IN,
  input  logic [DATA_W-1:0] WMASK_,
  output logic [DATA_W-1:0] DATA_OUT,
  output logic              RD_VALID_,
  output logic              READY_,
  output logic              BUSY_,
  output logic              DROP_
);

  localparam int NBANKS     = 1 << BANK_W;
  localparam int IDX_W      = ADDR_W - BANK_W;
  localparam int BANK_DEPTH = 1 << IDX_W;
  localparam int DEPTH      = 1 << ADDR_W;
  localparam logic [IDX_W-1:0] IDX_LAST = '1;

  typedef enum logic {S_CLEAR, S_ACTIVE} state_t;

  state_t state_q, state_d;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [IDX_W-1:0]  clr_idx_q, clr_idx_d;
  logic [DATA_W-1:0] data_out_q;
  logic              rd_valid_q;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              drop_q;
  logic              clr_en;
  logic              clr_last;
  logic              wr_acc;
  logic              rd_acc;

  // A request is only accepted when the registered READY_ is high, so the
  // clear engine and user writes never touch the array in the same cycle.
  assign wr_acc = REQ_ && ready_q && R_W_;
  assign rd_acc = REQ_ && ready_q && !R_W_;

  // State register; reset picks the start state from CLEAR_ON_RESET.
  always_ff @(posedge CLK_) begin
    if (!RST_N_) begin
      state_q <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_ACTIVE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: leave CLEAR once the last bank index has been zeroed.
  always_comb begin
    state_d = state_q;
    if (state_q == S_CLEAR && clr_idx_q == IDX_LAST) begin
      state_d = S_ACTIVE;
    end
  end

  // Output/control decode for the clear engine and the handshake flags.
  always_comb begin
    clr_en    = (state_q == S_CLEAR);
    clr_last  = clr_en && (clr_idx_q == IDX_LAST);
    clr_idx_d = clr_en ? clr_idx_q + 1'b1 : clr_idx_q;
    ready_d   = (state_q == S_ACTIVE) || clr_last;
    busy_d    = clr_en && !clr_last;
  end

  // Control registers: clear index, ready/busy, sticky drop, read strobe.
  always_ff @(posedge CLK_) begin
    if (!RST_N_) begin
      clr_idx_q  <= '0;
      ready_q    <= 1'b0;
      busy_q     <= (CLEAR_ON_RESET != 0);
      drop_q     <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      clr_idx_q  <= clr_idx_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      rd_valid_q <= rd_acc;
      if (REQ_ && !ready_q) begin
        drop_q <= 1'b1;
      end
    end
  end

  // Read data register: holds the last read value until the next read.
  always_ff @(posedge CLK_) begin
    if (!RST_N_) begin
      data_out_q <= '0;
    end else if (rd_acc) begin
      data_out_q <= mem_q[ADDR_];
    end
  end

  // Storage array: parallel clear of index i in every bank, or masked write.
  always_ff @(posedge CLK_) begin
    if (RST_N_) begin
      if (clr_en) begin
        for (int b = 0; b < NBANKS; b++) begin
          mem_q[ADDR_W'(b * BANK_DEPTH) | ADDR_W'(clr_idx_q)] <= '0;
        end
      end else if (wr_acc) begin
        mem_q[ADDR_] <= (mem_q[ADDR_] & ~WMASK_) | (DATA_IN & WMASK_);
      end
    end
  end

  assign DATA_OUT  = data_out_q;
  assign RD_VALID_ = rd_valid_q;
  assign READY_    = ready_q;
  assign BUSY_     = busy_q;
  assign DROP_     = drop_q;

endmodule
